// File: rtl/de2_115_web_qsys_cpu_div_pkg.sv
// Shared types and helpers for the CPU divide cell and its datapath step.
package de2_115_web_qsys_cpu_div_pkg;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Width of the iteration counter, which must hold DATA_W-1.
  function automatic int div_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/de2_115_web_qsys_cpu_div_step.sv
// One radix-2 restoring divide step: shift in the next dividend bit, then
// subtract the divisor if it fits. Purely combinational so it can later be
// chained for a radix-4 iteration.
module de2_115_web_qsys_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              q_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtraction. The partial remainder stays below the divisor (or, for
  // a zero divisor, below 2^(DATA_W-1) before the final step), so the extra
  // top bit of the difference is a reliable borrow flag.
  always_comb begin
    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    shifted  = {rem, q_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[DATA_W];
    next_rem = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/de2_115_web_qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu in the A-stage. Operands
// are converted to magnitudes on accept, divided over DATA_W cycles, then
// sign-corrected into held output registers.
module de2_115_web_qsys_cpu_div_cell
  import de2_115_web_qsys_cpu_div_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit ZERO_EARLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  input  logic              A_div_signed,
  input  logic              A_div_start,
  input  logic              A_div_kill,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quotient,
  output logic [DATA_W-1:0] A_div_remainder
);

  localparam int CNT_W = div_cnt_w(DATA_W);
  localparam logic [DATA_W-1:0] DIV_ZERO_Q = '1;

  div_state_e        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] divisor_r;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;

  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic              src2_zero;
  logic [DATA_W-1:0] next_rem;
  logic              q_bit;

  // Operand magnitudes; |most-negative| wraps to itself and is used unsigned.
  assign src1_neg  = A_div_signed & A_div_src1[DATA_W-1];
  assign src2_neg  = A_div_signed & A_div_src2[DATA_W-1];
  assign abs1      = src1_neg ? -A_div_src1 : A_div_src1;
  assign abs2      = src2_neg ? -A_div_src2 : A_div_src2;
  assign src2_zero = (A_div_src2 == '0);

  de2_115_web_qsys_cpu_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem_r),
    .q_msb    (quo_r[DATA_W-1]),
    .divisor  (divisor_r),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // Sequencer and datapath: accept, iterate, sign-fix, pulse done.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      A_div_busy      <= 1'b0;
      A_div_done      <= 1'b0;
      A_div_quotient  <= '0;
      A_div_remainder <= '0;
      rem_r           <= '0;
      quo_r           <= '0;
      divisor_r       <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      div_zero        <= 1'b0;
    end else if (A_div_kill) begin
      // Flush: abandon any operation, drop a coincident start, keep old results.
      state      <= IDLE;
      A_div_busy <= 1'b0;
      A_div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          A_div_done <= 1'b0;
          if (A_div_start) begin
            quo_r      <= abs1;
            divisor_r  <= abs2;
            neg_q      <= src1_neg ^ src2_neg;
            neg_r      <= src1_neg;
            div_zero   <= src2_zero;
            count      <= CNT_W'(DATA_W - 1);
            A_div_busy <= 1'b1;
            if (ZERO_EARLY && src2_zero) begin
              // Skipping the loop: the remainder is simply the dividend magnitude.
              rem_r <= abs1;
              state <= FIX;
            end else begin
              rem_r <= '0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          rem_r <= next_rem;
          quo_r <= {quo_r[DATA_W-2:0], q_bit};
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        FIX: begin
          A_div_quotient  <= div_zero ? DIV_ZERO_Q : (neg_q ? -quo_r : quo_r);
          A_div_remainder <= neg_r ? -rem_r : rem_r;
          A_div_done      <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          A_div_done <= 1'b0;
          A_div_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
